// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: payload width and control-field layout.
package pipe_stage_reg_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OCC_W = 2;

    // Control-field layout carried opaquely by every pipeline stage (LSB first: reg_write)
    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] funct3;
        logic       mem_access;
        logic [1:0] wb_sel;
        logic [4:0] rd;
        logic       reg_write;
    } ctrl_t;

    localparam int unsigned CTRL_BITS = $bits(ctrl_t);

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bus of a pipeline stage: upstream beat in, downstream beat out.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = pipe_stage_reg_pkg::XLEN,
    parameter int unsigned CTRL_W = pipe_stage_reg_pkg::CTRL_BITS
) ();

    logic                                  in_valid;
    logic                                  in_ready;
    logic [DATA_W-1:0]                     in_data;
    logic [CTRL_W-1:0]                     in_ctrl;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [DATA_W-1:0]                     out_data;
    logic [CTRL_W-1:0]                     out_ctrl;
    logic [pipe_stage_reg_pkg::OCC_W-1:0]  occupancy;

    // Driver side: produces input beats, consumes output beats
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );

    // Stage side
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );

endinterface

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid bit, control and payload with load/clear.
module pipe_entry
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned CTRL_W = CTRL_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [CTRL_W-1:0] ld_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
    logic [DATA_W-1:0] data_d,  data_q;

    // Next entry state: clear wins over load; ctrl zeroed whenever the entry empties
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            ctrl_d  = ld_ctrl;
            data_d  = ld_data;
        end
    end

    // Valid and control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Payload register; stale contents of an empty entry are never observed as valid
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: plain 1-entry register or 2-entry skid buffer.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned CTRL_W = CTRL_BITS,
    parameter int unsigned SKID   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_stage_reg_if.slave  bus
);

    logic              in_fire;
    logic              out_fire;
    logic              in_ready_int;
    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_ld_data;
    logic [CTRL_W-1:0] main_ld_ctrl;

    assign in_fire  = bus.in_valid && in_ready_int;
    assign out_fire = main_v && bus.out_ready;

    // Main entry always presents the oldest beat
    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load    (main_load),
        .clear   (main_clear),
        .ld_data (main_ld_data),
        .ld_ctrl (main_ld_ctrl),
        .valid   (main_v),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_load;
            logic              skid_clear;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Second entry catches a beat accepted while main is stalled
            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load    (skid_load),
                .clear   (skid_clear),
                .ld_data (bus.in_data),
                .ld_ctrl (bus.in_ctrl),
                .valid   (skid_v),
                .data    (skid_data),
                .ctrl    (skid_ctrl)
            );

            // Registered ready: accept only while the skid slot is free
            assign in_ready_int = !skid_v;

            // Entry steering: skid refills main on drain, new beats fill the first free slot
            always_comb begin
                main_load    = 1'b0;
                main_clear   = flush;
                main_ld_data = bus.in_data;
                main_ld_ctrl = bus.in_ctrl;
                skid_load    = 1'b0;
                skid_clear   = flush;
                if (!flush) begin
                    if (!main_v) begin
                        main_load = in_fire;
                    end else if (out_fire) begin
                        if (skid_v) begin
                            main_load    = 1'b1;
                            main_ld_data = skid_data;
                            main_ld_ctrl = skid_ctrl;
                            skid_load    = in_fire;
                            skid_clear   = !in_fire;
                        end else begin
                            main_load  = in_fire;
                            main_clear = !in_fire;
                        end
                    end else begin
                        skid_load = in_fire;
                    end
                end
            end
        end else begin : g_reg
            assign skid_v = 1'b0;

            // Ready passes straight through from downstream
            assign in_ready_int = !main_v || bus.out_ready;

            // Single entry: load on accept, empty on drain without refill
            always_comb begin
                main_load    = in_fire;
                main_clear   = flush || (out_fire && !in_fire);
                main_ld_data = bus.in_data;
                main_ld_ctrl = bus.in_ctrl;
            end
        end
    endgenerate

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.occupancy = OCC_W'(main_v) + OCC_W'(skid_v);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: one plain-register stage and one skid stage fed the same stimulus.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef logic [DW+CW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    int    errors = 0;
    int    checks = 0;
    beat_t q0[$];
    beat_t q1[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.in_ctrl   = in_ctrl;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.in_ctrl   = in_ctrl;
    assign bus1.out_ready = out_ready;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus0.slave)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus1.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int idx);
        return (idx == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qfront(input int idx);
        return (idx == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int idx);
        if (idx == 0) void'(q0.pop_front());
        else          void'(q1.pop_front());
    endtask

    task automatic qpush(input int idx, input beat_t b);
        if (idx == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic qclear(input int idx);
        if (idx == 0) q0.delete();
        else          q1.delete();
    endtask

    // FIFO reference model: compares presented outputs, then applies this cycle's transfers
    task automatic mon(input int idx, input logic skid, input logic ov, input logic ir,
                       input logic [1:0] occ, input logic [DW-1:0] od, input logic [CW-1:0] oc);
        int    sz;
        beat_t front;
        logic  exp_ir;
        string tag;
        tag = (idx == 0) ? "s0" : "s1";
        if (rst) begin
            qclear(idx);
            return;
        end
        sz     = qsize(idx);
        exp_ir = skid ? (sz < 2) : ((sz == 0) || out_ready);
        chk({tag, "_occupancy"}, 32'(occ), 32'(sz));
        chk({tag, "_out_valid"}, 32'(ov), 32'(sz != 0));
        chk({tag, "_in_ready"},  32'(ir), 32'(exp_ir));
        if (sz != 0) begin
            front = qfront(idx);
            chk({tag, "_out_data"}, 32'(od), 32'(front[DW-1:0]));
            chk({tag, "_out_ctrl"}, 32'(oc), 32'(front[DW+CW-1:DW]));
        end else begin
            chk({tag, "_bubble_ctrl"}, 32'(oc), 32'h0);
        end
        if ((sz != 0) && out_ready) qpop(idx);
        if (flush) qclear(idx);
        else if (in_valid && exp_ir) qpush(idx, {in_ctrl, in_data});
    endtask

    always @(negedge clk) mon(0, 1'b0, bus0.out_valid, bus0.in_ready, bus0.occupancy, bus0.out_data, bus0.out_ctrl);
    always @(negedge clk) mon(1, 1'b1, bus1.out_valid, bus1.in_ready, bus1.occupancy, bus1.out_data, bus1.out_ctrl);

    function automatic logic [CW-1:0] mk_ctrl(input int i);
        ctrl_t c;
        c            = '0;
        c.reg_write  = 1'b1;
        c.rd         = 5'(i);
        c.mem_access = i[0];
        c.funct3     = 3'(i);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed scenarios followed by a random regression
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_ctrl = 16'hFFFF;
        in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        step(); step();
        rst = 1'b0; in_valid = 1'b0; in_ctrl = '0;
        @(negedge clk);
        chk("rst_s0_out_valid", 32'(bus0.out_valid), 32'h0);
        chk("rst_s0_out_ctrl",  32'(bus0.out_ctrl),  32'h0);
        chk("rst_s0_occupancy", 32'(bus0.occupancy), 32'h0);
        chk("rst_s0_in_ready",  32'(bus0.in_ready),  32'h1);
        chk("rst_s1_out_valid", 32'(bus1.out_valid), 32'h0);
        chk("rst_s1_out_ctrl",  32'(bus1.out_ctrl),  32'h0);
        chk("rst_s1_occupancy", 32'(bus1.occupancy), 32'h0);
        chk("rst_s1_in_ready",  32'(bus1.in_ready),  32'h1);
        step();

        // Streaming 1..8 with no back-pressure
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_ctrl = mk_ctrl(i);
            @(negedge clk);
            if (i > 1) begin
                chk("stream_s0_data", bus0.out_data, 32'(i - 1));
                chk("stream_s1_data", bus1.out_data, 32'(i - 1));
                chk("stream_s0_occ",  32'(bus0.occupancy), 32'h1);
                chk("stream_s1_occ",  32'(bus1.occupancy), 32'h1);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_s0_last", bus0.out_data, 32'h8);
        chk("stream_s1_last", bus1.out_data, 32'h8);
        step();
        @(negedge clk);
        chk("stream_s1_empty", 32'(bus1.occupancy), 32'h0);
        step();

        // Back-pressure fills the skid stage, then drains in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; in_ctrl = mk_ctrl(3);
        @(negedge clk); step();
        in_data = 32'h22; in_ctrl = mk_ctrl(4);
        @(negedge clk);
        chk("bp_s0_in_ready", 32'(bus0.in_ready), 32'h0);
        step();
        in_data = 32'h44; in_ctrl = mk_ctrl(5);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_s1_occ",      32'(bus1.occupancy), 32'h2);
            chk("full_s1_in_ready", 32'(bus1.in_ready),  32'h0);
            chk("full_s1_data",     bus1.out_data,       32'h11);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("drain_s1_first", bus1.out_data, 32'h11);
        step();
        @(negedge clk);
        chk("drain_s1_second", bus1.out_data, 32'h22);
        chk("drain_s1_occ1",   32'(bus1.occupancy), 32'h1);
        step();
        @(negedge clk);
        chk("drain_s1_occ0",   32'(bus1.occupancy), 32'h0);
        chk("drain_s1_valid",  32'(bus1.out_valid), 32'h0);
        step();

        // Plain register stalls with combinational ready
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = mk_ctrl(6);
        @(negedge clk); step();
        in_data = 32'h66; in_ctrl = mk_ctrl(7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_s0_in_ready", 32'(bus0.in_ready), 32'h0);
            chk("stall_s0_data",     bus0.out_data,      32'h55);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_s0_in_ready", 32'(bus0.in_ready), 32'h1);
        chk("release_s0_data",     bus0.out_data,      32'h55);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_s0_next", bus0.out_data, 32'h66);
        step();
        repeat (3) step();

        // Flush while full collides with a new beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h01; in_ctrl = mk_ctrl(8);
        @(negedge clk); step();
        in_data = 32'h02; in_ctrl = mk_ctrl(9);
        @(negedge clk); step();
        flush = 1'b1; in_data = 32'h33; in_ctrl = mk_ctrl(10);
        @(negedge clk);
        chk("flush_s1_occ_before", 32'(bus1.occupancy), 32'h2);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_s1_occ",   32'(bus1.occupancy), 32'h0);
        chk("flush_s1_valid", 32'(bus1.out_valid), 32'h0);
        chk("flush_s1_ctrl",  32'(bus1.out_ctrl),  32'h0);
        chk("flush_s0_valid", 32'(bus0.out_valid), 32'h0);
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // Random regression against the FIFO model
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            in_data   = $urandom;
            in_ctrl   = 16'($urandom);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
